// File: rtl/zorro_pkg.sv
// Shared Zorro II AutoConfig definitions.
//   - Register offsets as seen on AL (A6..A1), i.e. byte offset / 2.
//   - Board size encoding and the helper that turns a size code into the
//     mask of AH (A23..A16) bits that take part in the base-address match.
package zorro_pkg;

  // Read-only ROM nibbles (byte offsets $00..$16, $40/$42)
  localparam logic [5:0] ER_TYPE    = 6'h00;  // board type nibble
  localparam logic [5:0] ER_SIZE    = 6'h01;  // chain bit + size code
  localparam logic [5:0] ER_PROD    = 6'h02;  // product id, two nibbles
  localparam logic [5:0] ER_FLAGS   = 6'h04;  // memlist / flags nibble
  localparam logic [5:0] ER_MFG     = 6'h08;  // manufacturer id, four nibbles
  localparam logic [5:0] ER_ZERO    = 6'h20;  // two reads that return zero

  // Write-only configuration registers
  localparam logic [5:0] EC_BASE_HI = 6'h24;  // $48: A23..A20, configures
  localparam logic [5:0] EC_BASE_LO = 6'h25;  // $4A: A19..A16
  localparam logic [5:0] EC_SHUTUP  = 6'h26;  // $4C: board opts out

  typedef enum logic [2:0] {
    SZ_8M   = 3'd0,
    SZ_64K  = 3'd1,
    SZ_128K = 3'd2,
    SZ_256K = 3'd3,
    SZ_512K = 3'd4,
    SZ_1M   = 3'd5,
    SZ_2M   = 3'd6,
    SZ_4M   = 3'd7
  } zsize_e;

  // Bits of AH that must equal the board base; lower bits address inside
  // the board.
  function automatic logic [7:0] size_mask(input logic [2:0] sz);
    case (zsize_e'(sz))
      SZ_8M:   size_mask = 8'h80;
      SZ_4M:   size_mask = 8'hC0;
      SZ_2M:   size_mask = 8'hE0;
      SZ_1M:   size_mask = 8'hF0;
      SZ_512K: size_mask = 8'hF8;
      SZ_256K: size_mask = 8'hFC;
      SZ_128K: size_mask = 8'hFE;
      default: size_mask = 8'hFF;   // 64K
    endcase
  endfunction

endpackage

// File: rtl/bus_strobe_sync.sv
// Two-flop synchroniser for the asynchronous 68000 strobes _AS and _UDS.
//   CLK, _RST   : bus clock, async active-low reset
//   _AS, _UDS   : raw strobes (active low)
//   as_s        : synchronised _AS
//   as_rise     : one-CLK pulse when as_s goes high (end of bus cycle)
//   uds_fall    : one-CLK pulse when synchronised _UDS goes low
module bus_strobe_sync (
  input  logic CLK,
  input  logic _RST,
  input  logic _AS,
  input  logic _UDS,
  output logic as_s,
  output logic as_rise,
  output logic uds_fall
);

  // [0] metastability stage, [1] synchronised value
  logic [1:0] as_sync_q, uds_sync_q;
  logic       as_prev_q, uds_prev_q;

  // Strobes idle high, so reset to 1: no spurious edge after reset release,
  // but a strobe already low at release is seen as a fresh falling edge.
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      as_sync_q  <= 2'b11;
      uds_sync_q <= 2'b11;
      as_prev_q  <= 1'b1;
      uds_prev_q <= 1'b1;
    end else begin
      as_sync_q  <= {as_sync_q[0], _AS};
      uds_sync_q <= {uds_sync_q[0], _UDS};
      as_prev_q  <= as_sync_q[1];
      uds_prev_q <= uds_sync_q[1];
    end
  end

  assign as_s     = as_sync_q[1];
  assign as_rise  = as_sync_q[1] & ~as_prev_q;
  assign uds_fall = ~uds_sync_q[1] & uds_prev_q;

endmodule

// File: rtl/zorro2_autoconfig_multi.sv
// Zorro II AutoConfig responder for 1..4 logical boards sharing one slot.
// Boards enumerate in index order; the lowest board that is neither
// configured nor shut up answers at $E8xxxx.
//   CLK, _RST        : bus clock, async active-low reset
//   AH, AL           : A23..A16 and A6..A1
//   D_i              : D15..D12 write data
//   _AS, _UDS, RW    : 68000 strobes (raw, active low) and read/write
//   _configin        : chain input (active low)
//   _configout       : chain output, low once every board is done
//   D_o, config_oe   : ROM nibble and its drive enable
//   DTACK            : registered, positive logic
//   ce               : per-board chip enables
module zorro2_autoconfig_multi
  import zorro_pkg::*;
#(
  parameter int                      NUM_BOARDS = 2,
  parameter logic [3*NUM_BOARDS-1:0] SIZE_CODE  = {3'b110, 3'b001},
  parameter logic [NUM_BOARDS-1:0]   MEMLIST    = 2'b01,
  parameter logic [8*NUM_BOARDS-1:0] PROD_ID    = {8'h02, 8'h30},
  parameter logic [15:0]             MFG_ID     = 16'h5A5A,
  parameter int                      DTACK_WAIT = 1
) (
  input  logic                  CLK,
  input  logic                  _RST,
  input  logic [7:0]            AH,
  input  logic [5:0]            AL,
  input  logic [3:0]            D_i,
  input  logic                  _AS,
  input  logic                  _UDS,
  input  logic                  RW,
  input  logic                  _configin,
  output logic                  _configout,
  output logic [3:0]            D_o,
  output logic                  config_oe,
  output logic                  DTACK,
  output logic [NUM_BOARDS-1:0] ce
);

  localparam logic [2:0] WAIT_CNT = 3'(DTACK_WAIT);

  logic as_s, as_rise, uds_fall;

  bus_strobe_sync u_sync (
    .CLK      (CLK),
    ._RST     (_RST),
    ._AS      (_AS),
    ._UDS     (_UDS),
    .as_s     (as_s),
    .as_rise  (as_rise),
    .uds_fall (uds_fall)
  );

  logic [NUM_BOARDS-1:0]      cfg_q, cfg_d, shut_q, shut_d;
  logic [NUM_BOARDS-1:0][7:0] base_q, base_d;
  logic                       done_q, done_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic                       dtack_q, dtack_d;

  logic [1:0] act;
  logic       all_done, ac_hit, commit, any_ce;

  // Lowest-index board still waiting for configuration.
  always_comb begin
    act = 2'd0;
    for (int i = NUM_BOARDS - 1; i >= 0; i--)
      if (!cfg_q[i] && !shut_q[i]) act = 2'(i);
  end

  assign all_done = &(cfg_q | shut_q);
  assign ac_hit   = (AH == 8'hE8) && !_configin && !all_done && !as_s;

  // ROM of the active board
  logic [2:0] cur_size;
  logic [7:0] cur_prod;
  logic       cur_mem, cur_chain;
  logic [3:0] rom_nib;

  always_comb begin
    cur_size  = SIZE_CODE[2:0];
    cur_prod  = PROD_ID[7:0];
    cur_mem   = MEMLIST[0];
    cur_chain = (NUM_BOARDS > 1);
    for (int i = 0; i < NUM_BOARDS; i++) begin
      if (act == 2'(i)) begin
        cur_size  = SIZE_CODE[3*i +: 3];
        cur_prod  = PROD_ID[8*i +: 8];
        cur_mem   = MEMLIST[i];
        cur_chain = (i < NUM_BOARDS - 1);   // another board follows in the slot
      end
    end
    case (AL)
      ER_TYPE:         rom_nib = cur_mem ? 4'hE : 4'hC;
      ER_SIZE:         rom_nib = {cur_chain, cur_size};
      ER_PROD:         rom_nib = ~cur_prod[7:4];
      ER_PROD + 6'd1:  rom_nib = ~cur_prod[3:0];
      ER_FLAGS:        rom_nib = cur_mem ? 4'h7 : 4'hF;
      ER_MFG:          rom_nib = ~MFG_ID[15:12];
      ER_MFG + 6'd1:   rom_nib = ~MFG_ID[11:8];
      ER_MFG + 6'd2:   rom_nib = ~MFG_ID[7:4];
      ER_MFG + 6'd3:   rom_nib = ~MFG_ID[3:0];
      ER_ZERO,
      ER_ZERO + 6'd1:  rom_nib = 4'h0;
      default:         rom_nib = 4'hF;
    endcase
  end

  // Chip enables: only the AH bits above the board size are decoded.
  always_comb begin
    ce = '0;
    for (int i = 0; i < NUM_BOARDS; i++)
      ce[i] = cfg_q[i] &&
              ((AH & size_mask(SIZE_CODE[3*i +: 3])) ==
               (base_q[i] & size_mask(SIZE_CODE[3*i +: 3])));
  end
  assign any_ce = |ce;

  // One commit per bus cycle; done_q masks later _UDS edges until _AS ends.
  assign commit = uds_fall && ac_hit && !RW && !done_q;

  always_comb begin
    cfg_d  = cfg_q;
    shut_d = shut_q;
    base_d = base_q;
    done_d = done_q;
    if (as_rise)     done_d = 1'b0;
    else if (commit) done_d = 1'b1;
    for (int i = 0; i < NUM_BOARDS; i++) begin
      if (commit && act == 2'(i)) begin
        case (AL)
          EC_BASE_LO: base_d[i][3:0] = D_i;
          EC_BASE_HI: begin
            base_d[i][7:4] = D_i;
            cfg_d[i]       = 1'b1;
          end
          EC_SHUTUP:  shut_d[i] = 1'b1;
          default:    ;
        endcase
      end
    end
  end

  // Wait-state counter. DTACK holds once asserted so that a configuring
  // write, which can drop ac_hit mid-cycle, still completes its handshake.
  always_comb begin
    cnt_d   = cnt_q;
    dtack_d = 1'b0;
    if (as_s) begin
      cnt_d = 3'd0;
    end else begin
      if ((ac_hit || any_ce) && cnt_q < WAIT_CNT) cnt_d = cnt_q + 3'd1;
      dtack_d = dtack_q || ((ac_hit || any_ce) && cnt_q == WAIT_CNT);
    end
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      cfg_q   <= '0;
      shut_q  <= '0;
      base_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= 3'd0;
      dtack_q <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      shut_q  <= shut_d;
      base_q  <= base_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      dtack_q <= dtack_d;
    end
  end

  assign D_o        = rom_nib;
  assign config_oe  = ac_hit & RW;
  assign DTACK      = dtack_q;
  assign _configout = !all_done;

endmodule

// File: tb/tb_zorro2_autoconfig_multi.sv
module tb_zorro2_autoconfig_multi;
  localparam int          NB    = 2;
  localparam logic [5:0]  SIZES = {3'b110, 3'b001};   // board0 64K, board1 2M
  localparam logic [1:0]  MEML  = 2'b01;
  localparam logic [15:0] PRODS = {8'h02, 8'h30};
  localparam logic [15:0] MFG   = 16'h5A5A;
  localparam int          WAITC = 1;

  logic          clk = 1'b0;
  logic          rst_n, as_n, uds_n, rw, cfgin_n;
  logic [7:0]    ah;
  logic [5:0]    al;
  logic [3:0]    d_i;
  logic          cfgout_n, oe, dtack;
  logic [3:0]    d_o;
  logic [NB-1:0] ce;

  zorro2_autoconfig_multi #(
    .NUM_BOARDS(NB), .SIZE_CODE(SIZES), .MEMLIST(MEML),
    .PROD_ID(PRODS), .MFG_ID(MFG), .DTACK_WAIT(WAITC)
  ) dut (
    .CLK(clk), ._RST(rst_n), .AH(ah), .AL(al), .D_i(d_i),
    ._AS(as_n), ._UDS(uds_n), .RW(rw), ._configin(cfgin_n),
    ._configout(cfgout_n), .D_o(d_o), .config_oe(oe), .DTACK(dtack), .ce(ce)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         cfg_m[NB];
  bit         shut_m[NB];
  logic [7:0] base_m[NB];

  function automatic void m_clear();
    for (int i = 0; i < NB; i++) begin
      cfg_m[i] = 0; shut_m[i] = 0; base_m[i] = 8'h00;
    end
  endfunction

  function automatic int m_act();
    for (int i = 0; i < NB; i++) if (!cfg_m[i] && !shut_m[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] m_rom(input int b, input logic [5:0] a);
    logic [5:0] sz_all; logic [15:0] pids; logic [15:0] mfg; logic [1:0] mls;
    logic [2:0] sz; logic [7:0] pid; logic ml;
    sz_all = SIZES; pids = PRODS; mfg = MFG; mls = MEML;
    sz = sz_all[3*b +: 3]; pid = pids[8*b +: 8]; ml = mls[b];
    case (a)
      6'h00: return ml ? 4'hE : 4'hC;
      6'h01: return {(b < NB - 1) ? 1'b1 : 1'b0, sz};
      6'h02: return ~pid[7:4];
      6'h03: return ~pid[3:0];
      6'h04: return ml ? 4'h7 : 4'hF;
      6'h08: return ~mfg[15:12];
      6'h09: return ~mfg[11:8];
      6'h0A: return ~mfg[7:4];
      6'h0B: return ~mfg[3:0];
      6'h20, 6'h21: return 4'h0;
      default: return 4'hF;
    endcase
  endfunction

  // Board of 2^n 64K pages decodes the top (9 - code) address bits; 8M uses 1.
  function automatic logic [NB-1:0] m_ce(input logic [7:0] a);
    logic [5:0] sz_all; logic [2:0] sz; logic [NB-1:0] r; int nbits, sh;
    sz_all = SIZES; r = '0;
    for (int i = 0; i < NB; i++) begin
      sz = sz_all[3*i +: 3];
      nbits = (sz == 3'd0) ? 1 : 9 - int'(sz);
      sh = 8 - nbits;
      if (cfg_m[i] && ((a >> sh) == (base_m[i] >> sh))) r[i] = 1'b1;
    end
    return r;
  endfunction

  typedef struct {
    bit            timed;
    bit            dtack;
    bit            oe;
    logic [3:0]    d;
    logic [NB-1:0] ce;
    bit            cfgout;
  } exp_t;
  exp_t exp_q[$];

  // ---------------- stimulus ----------------
  task automatic bus(input logic [7:0] a_h, input logic [5:0] a_l, input logic r_w,
                     input logic [3:0] dat, input logic cin_n, input int hold);
    exp_t e; int act; bit ac;
    act = m_act();
    ac  = (a_h == 8'hE8) && !cin_n && (act >= 0);
    e.timed = 1;
    e.dtack = ac || (m_ce(a_h) != '0);
    e.oe    = ac && r_w;
    e.d     = e.oe ? m_rom(act, a_l) : 4'h0;
    if (ac && !r_w) begin
      if (a_l == 6'h25) base_m[act][3:0] = dat;
      else if (a_l == 6'h24) begin base_m[act][7:4] = dat; cfg_m[act] = 1; end
      else if (a_l == 6'h26) shut_m[act] = 1;
    end
    e.ce     = m_ce(a_h);
    e.cfgout = (m_act() >= 0);
    exp_q.push_back(e);
    @(posedge clk); #1;
    ah = a_h; al = a_l; rw = r_w; d_i = dat; cfgin_n = cin_n; as_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 uds_n = 1'b0;
    repeat (hold) @(posedge clk);
    #1 uds_n = 1'b1; as_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_dtack"}, dtack, 0);
    chk({tag, "_oe"}, oe, 0);
    chk({tag, "_cfgout"}, cfgout_n, 1);
    chk({tag, "_ce"}, ce, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    #2 reset_checks("rst");
    m_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  // Reset lands while a $48 write holds _UDS low; after release the still-low
  // _UDS is a fresh commit to board 0.
  task automatic reset_mid_write();
    exp_t e;
    m_clear();
    base_m[0][7:4] = 4'h5; cfg_m[0] = 1;
    e.timed = 0; e.dtack = 1; e.oe = 0; e.d = 4'h0;
    e.ce = m_ce(8'hE8); e.cfgout = (m_act() >= 0);
    exp_q.push_back(e);
    @(posedge clk); #1;
    ah = 8'hE8; al = 6'h24; rw = 1'b0; d_i = 4'h5; cfgin_n = 1'b0; as_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 uds_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #2 reset_checks("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1 uds_n = 1'b1; as_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    int idx, dt_idx, oe_idx;
    logic [3:0] d_at;
    logic [NB-1:0] ce_last;
    logic co_last;
    bit in_cyc;
    exp_t e;
    in_cyc = 0; idx = 0; dt_idx = -1; oe_idx = -1; d_at = 0; ce_last = '0; co_last = 1;
    forever begin
      @(negedge clk);
      if (as_n === 1'b0) begin
        if (!in_cyc) begin
          in_cyc = 1; idx = 0; dt_idx = -1; oe_idx = -1; d_at = 4'h0;
          chk("dtack_idle", dtack, 0);
        end
        if (dtack === 1'b1 && dt_idx < 0) begin dt_idx = idx; d_at = d_o; end
        if (oe === 1'b1 && oe_idx < 0) oe_idx = idx;
        ce_last = ce; co_last = cfgout_n;
        idx++;
      end else if (in_cyc) begin
        in_cyc = 0;
        if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("dtack_seen", (dt_idx >= 0), e.dtack);
          if (e.timed) begin
            if (e.dtack) chk("dtack_lat", dt_idx, 2 + WAITC + 1);
            chk("oe_lat", oe_idx, e.oe ? 2 : -1);
          end
          if (e.oe && dt_idx >= 0) chk("rom_nibble", d_at, e.d);
          chk("ce_end", ce_last, e.ce);
          chk("cfgout_end", co_last, e.cfgout);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [5:0] al_list [12];
    int r, b;
    logic [7:0] a;
    al_list = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0A, 6'h0B,
                6'h20, 6'h21, 6'h05};
    rst_n = 1'b0; as_n = 1'b1; uds_n = 1'b1; rw = 1'b1; cfgin_n = 1'b0;
    ah = 8'h00; al = 6'h00; d_i = 4'h0;
    m_clear();
    #3;
    reset_checks("init");
    chk("init_do", d_o, m_rom(0, 6'h00));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // ROM of board 0
    for (int i = 0; i < 12; i++) bus(8'hE8, al_list[i], 1'b1, 4'h0, 1'b0, 6);
    // board 0 base $20
    bus(8'hE8, 6'h25, 1'b0, 4'h0, 1'b0, 6);
    bus(8'hE8, 6'h24, 1'b0, 4'h2, 1'b0, 6);
    bus(8'h20, 6'h00, 1'b1, 4'h0, 1'b0, 6);
    bus(8'h21, 6'h00, 1'b1, 4'h0, 1'b0, 6);
    bus(8'h3F, 6'h00, 1'b0, 4'h0, 1'b0, 6);
    // board 1 now served
    bus(8'hE8, 6'h00, 1'b1, 4'h0, 1'b0, 6);
    bus(8'hE8, 6'h01, 1'b1, 4'h0, 1'b0, 6);
    bus(8'hE8, 6'h25, 1'b0, 4'h4, 1'b0, 6);
    bus(8'hE8, 6'h24, 1'b0, 4'hE, 1'b0, 6);
    bus(8'hE5, 6'h00, 1'b1, 4'h0, 1'b0, 6);
    bus(8'hE8, 6'h00, 1'b1, 4'h0, 1'b0, 6);
    bus(8'hD4, 6'h00, 1'b1, 4'h0, 1'b0, 6);
    bus(8'h20, 6'h00, 1'b1, 4'h0, 1'b1, 6);   // _configin high: ce stays live

    // shut up board 0
    do_reset();
    bus(8'hE8, 6'h26, 1'b0, 4'h0, 1'b0, 6);
    bus(8'hE8, 6'h01, 1'b1, 4'h0, 1'b0, 6);
    bus(8'h00, 6'h00, 1'b1, 4'h0, 1'b0, 6);

    // _UDS held 10 CLK: single commit
    do_reset();
    bus(8'hE8, 6'h24, 1'b0, 4'h7, 1'b0, 10);
    bus(8'hE8, 6'h01, 1'b1, 4'h0, 1'b0, 6);
    bus(8'h70, 6'h00, 1'b1, 4'h0, 1'b0, 6);

    // reset in the middle of a write
    do_reset();
    reset_mid_write();
    bus(8'hE8, 6'h01, 1'b1, 4'h0, 1'b0, 6);
    bus(8'h50, 6'h00, 1'b1, 4'h0, 1'b0, 6);

    // randomized traffic
    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 99);
      if (r < 4) do_reset();
      r = $urandom_range(0, 99);
      if (r < 40)
        bus(8'hE8, al_list[$urandom_range(0, 11)] ^ (($urandom_range(0, 5) == 0) ? 6'(($urandom_range(0, 63))) : 6'h00),
            1'b1, 4'h0, ($urandom_range(0, 7) == 0), 6);
      else if (r < 60)
        bus(8'hE8, 6'h25, 1'b0, 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), 6);
      else if (r < 75)
        bus(8'hE8, 6'h24, 1'b0, 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), 6);
      else if (r < 80)
        bus(8'hE8, 6'h26, 1'b0, 4'h0, ($urandom_range(0, 7) == 0), 6);
      else begin
        b = $urandom_range(0, NB - 1);
        if (cfg_m[b] && $urandom_range(0, 1) == 1)
          a = base_m[b] ^ (($urandom_range(0, 2) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7)));
        else
          a = 8'($urandom_range(0, 255));
        bus(a, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0), 6);
      end
    end

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
